ov7670_pixel_packer: RTL
========================

Name: ov7670_pixel_packer

Overview:
- Downstream stage of the OV7670 capture block.
- Consumes the captured byte stream (pixel byte, byte strobe, frame and line markers) and pairs bytes into RGB565 pixels.
- Converts each pixel to 12-bit RGB444 for the Nexys-4 DDR VGA DAC.
- Emits write strobes with linear addresses into a dual-port frame buffer; a later display stage reads that buffer.

Parameters:
- H_RES, 320, active pixels per line.
- V_RES, 240, active lines per frame.
- ADDR_W, 17, frame buffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- HI_BYTE_FIRST, 1, 1 = first byte of a pair is RGB565[15:8]; 0 = first byte is [7:0].

Ports:
- clk  in  1  block clock; all inputs are synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  captured camera byte.
- in_valid  in  1  in_data is valid this cycle.
- in_frame_start  in  1  one-cycle pulse at start of frame; also implies line start.
- in_line_start  in  1  one-cycle pulse at start of each line.
- in_frame_valid  in  1  high for the duration of a frame.
- wr_en  out  1  frame buffer write strobe.
- wr_addr  out  ADDR_W  linear write address, computed as y*H_RES + x.
- wr_data  out  12  RGB444 pixel as {R[3:0], G[3:0], B[3:0]}.
- frame_done  out  1  one-cycle pulse at end of frame.
- frame_count  out  16  completed frames, wraps modulo 2^16.
- line_err  out  1  sticky flag: a line ended with a byte count other than 2*H_RES.
- overflow  out  1  sticky flag: a pixel fell outside H_RES x V_RES and was dropped.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; byte phase 0; x, y and line_base 0.
- FSM states:
  - IDLE -> CAPTURE on in_frame_start.
  - CAPTURE -> END when in_frame_valid falls (sampled high last cycle, low now).
  - END -> IDLE unconditionally after 1 cycle.
  - END pulses frame_done and increments frame_count.
  - in_frame_start seen in any state: restart the frame (x=0, y=0, line_base=0, phase=0) and go to CAPTURE; no frame_done for the abandoned frame.
- Byte pairing: in CAPTURE, each in_valid byte toggles phase.
  - Phase 0 latches the byte into a holding register.
  - Phase 1 forms the 16-bit pixel: {hold, in_data} if HI_BYTE_FIRST, else {in_data, hold}.
- Colour conversion: RGB565 p -> wr_data = {p[15:12], p[10:7], p[4:1]}.
- Latency: wr_en, wr_addr and wr_data are registered; wr_en is high exactly 1 cycle after the phase-1 byte. wr_en is a single-cycle pulse per pixel; no backpressure.
- Addressing:
  - wr_addr = line_base + x.
  - x increments after each emitted pixel.
  - On in_line_start (not in the same cycle as frame_start): if the line has been started since frame start, line_base += H_RES and y += 1. Then x=0 and phase=0.
  - No multiplier is used.
- Line length check: at each in_line_start and at frame end, if the current line received any bytes and the count != 2*H_RES, set line_err. The first line of a frame is exempt until it has data.
- Bounds:
  - If x >= H_RES or y >= V_RES when a pixel completes: no wr_en, set overflow, x still increments (saturates at H_RES).
  - Addresses never exceed H_RES*V_RES-1.
- Simultaneous events:
  - A line or frame start with in_valid in the same cycle: the start is applied first, and the byte is the phase-0 byte of the new line.
  - A trailing odd byte at line or frame end is discarded, and line_err is set.
- in_valid outside CAPTURE is ignored.
- Reset mid-frame: immediate return to reset values; the next pixel requires a new in_frame_start.
- line_err and overflow clear only on reset.

Decomposition:
- Shared package ov7670_pkg: H_RES/V_RES defaults, FSM state encoding (IDLE, CAPTURE, END), and an RGB565->RGB444 conversion function.
- One natural sub-module: ov7670_rgb_convert (combinational 16->12 mapping), shared with future display or test-pattern blocks.

Test Plan:
- Reset, frame_start, then a full 320x240 frame of bytes 0xF8,0x00 (pure red): 76800 wr_en pulses, addresses 0..76799 in order, all wr_data=0xF00, one frame_done, frame_count=1, no flags.
- One line with pixel bytes 0x07,0xE0 then 0x00,0x1F, HI_BYTE_FIRST=1: wr_data 0x0F0 then 0x00F. Repeat with HI_BYTE_FIRST=0 and swapped byte order: same outputs.
- Second line_start after 640 bytes: first pixel of line 2 written at wr_addr=320.
- A line of 639 bytes, then line_start: line_err=1, odd byte dropped, next line starts at x=0 with correct line_base.
- 241 lines in one frame: no wr_en for line 241, overflow=1, last address 76799.
- Assert rst_n low mid-line after 100 pixels: all outputs 0 asynchronously. in_valid bytes without frame_start produce no wr_en. A new frame_start then writes from address 0.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 pixel path.
// Contents: default frame geometry and buffer address width, the packer FSM
// state encoding, and the RGB565 -> RGB444 reduction used for the VGA DAC.
package ov7670_pkg;

    localparam int unsigned H_RES_DEF  = 320;
    localparam int unsigned V_RES_DEF  = 240;
    localparam int unsigned ADDR_W_DEF = 17;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_END     = 2'd2
    } state_t;

    // Keep the top bits of each colour channel: R[4:1], G[5:2], B[4:1].
    function automatic logic [11:0] rgb565_to_444(input logic [15:0] p);
        return {p[15:12], p[10:7], p[4:1]};
    endfunction

endpackage

// File: rtl/ov7670_pixel_packer_if.sv
// Bus between the capture block, the pixel packer and the frame buffer.
// master : byte source (drives in_*), observes the write side.
// slave  : pixel packer (consumes in_*, drives wr_* and frame status).
//   in_data/in_valid          captured camera byte and its strobe
//   in_frame_start/line_start one-cycle frame / line start pulses
//   in_frame_valid            high for the duration of a frame
//   wr_en/wr_addr/wr_data     frame buffer write port (RGB444)
//   frame_done/frame_count    end-of-frame pulse and completed-frame count
//   line_err/overflow         sticky error flags
interface ov7670_pixel_packer_if #(
    parameter int ADDR_W = 17
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_frame_start;
    logic              in_line_start;
    logic              in_frame_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;
    logic              frame_done;
    logic [15:0]       frame_count;
    logic              line_err;
    logic              overflow;

    modport master (
        output in_data, in_valid, in_frame_start, in_line_start, in_frame_valid,
        input  wr_en, wr_addr, wr_data, frame_done, frame_count, line_err, overflow
    );

    modport slave (
        input  in_data, in_valid, in_frame_start, in_line_start, in_frame_valid,
        output wr_en, wr_addr, wr_data, frame_done, frame_count, line_err, overflow
    );
endinterface

// File: rtl/ov7670_rgb_convert.sv
// Combinational RGB565 -> RGB444 mapping, reusable by display and
// test-pattern blocks.
//   rgb565  in  16  source pixel
//   rgb444  out 12  {R[3:0], G[3:0], B[3:0]}
module ov7670_rgb_convert
    import ov7670_pkg::*;
(
    input  logic [15:0] rgb565,
    output logic [11:0] rgb444
);
    assign rgb444 = rgb565_to_444(rgb565);
endmodule

// File: rtl/ov7670_pixel_packer.sv
// Pairs captured camera bytes into RGB565 pixels, reduces them to RGB444 and
// writes them into a linear frame buffer at y*H_RES + x.
//   clk   in  block clock
//   rst_n in  asynchronous active-low reset
//   bus   slave side of ov7670_pixel_packer_if (byte stream in, writes out)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a frame start; bytes are ignored
// CAPTURE  | frame in progress; bytes are paired and written
// END      | one cycle after frame_valid fell; frame_done is high
module ov7670_pixel_packer
    import ov7670_pkg::*;
#(
    parameter int H_RES         = H_RES_DEF,
    parameter int V_RES         = V_RES_DEF,
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter bit HI_BYTE_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ov7670_pixel_packer_if.slave    bus
);
    localparam int XW = $clog2(H_RES + 1);
    localparam int YW = $clog2(V_RES + 1);
    localparam int CW = $clog2(2 * H_RES + 2);

    localparam logic [XW-1:0]     X_LIM      = XW'(H_RES);
    localparam logic [YW-1:0]     Y_LIM      = YW'(V_RES);
    localparam logic [YW-1:0]     Y_LAST     = YW'(V_RES - 1);
    localparam logic [CW-1:0]     LINE_BYTES = CW'(2 * H_RES);
    localparam logic [CW-1:0]     CNT_SAT    = CW'(2 * H_RES + 1);
    localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(H_RES);

    state_t            state, state_next;
    logic              fv_q;
    logic              phase;
    logic [7:0]        hold;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] line_base;
    logic [CW-1:0]     byte_cnt;
    logic              line_active;

    logic              frame_start, frame_end, line_start, byte_ok;
    logic              phase_eff, line_bad;
    logic [CW-1:0]     cnt_eff;
    logic [15:0]       pix565;
    logic [11:0]       pix444;

    always_comb begin
        frame_start = bus.in_frame_start;
        frame_end   = (state == ST_CAPTURE) && fv_q && !bus.in_frame_valid && !frame_start;
        line_start  = (state == ST_CAPTURE) && bus.in_line_start && !frame_start && !frame_end;
        byte_ok     = bus.in_valid && (frame_start || ((state == ST_CAPTURE) && !frame_end));
        // A start in the same cycle as a byte makes that byte the first of a pair.
        phase_eff   = (frame_start || line_start) ? 1'b0 : phase;
        cnt_eff     = (frame_start || line_start) ? '0 : byte_cnt;
        // An untouched line (count 0) is never an error.
        line_bad    = (byte_cnt != '0) && (byte_cnt != LINE_BYTES);
        pix565      = HI_BYTE_FIRST ? {hold, bus.in_data} : {bus.in_data, hold};
    end

    ov7670_rgb_convert u_rgb_convert (
        .rgb565 (pix565),
        .rgb444 (pix444)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (frame_start) state_next = ST_CAPTURE;
            ST_CAPTURE: if (frame_end)   state_next = ST_END;
            ST_END:     state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        if (frame_start) state_next = ST_CAPTURE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv_q            <= 1'b0;
            phase           <= 1'b0;
            hold            <= '0;
            x               <= '0;
            y               <= '0;
            line_base       <= '0;
            byte_cnt        <= '0;
            line_active     <= 1'b0;
            bus.wr_en       <= 1'b0;
            bus.wr_addr     <= '0;
            bus.wr_data     <= '0;
            bus.frame_done  <= 1'b0;
            bus.frame_count <= '0;
            bus.line_err    <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            bus.wr_en      <= 1'b0;
            bus.frame_done <= 1'b0;
            fv_q           <= bus.in_frame_valid;

            if (frame_end) begin
                bus.frame_done  <= 1'b1;
                bus.frame_count <= bus.frame_count + 16'd1;
                if (line_bad) bus.line_err <= 1'b1;
            end

            if (frame_start) begin
                x           <= '0;
                y           <= '0;
                line_base   <= '0;
                phase       <= 1'b0;
                byte_cnt    <= '0;
                line_active <= 1'b0;
            end else if (line_start) begin
                if (line_bad) bus.line_err <= 1'b1;
                // The first line_start after a frame start opens line 0
                // rather than advancing past it.
                if (line_active) begin
                    if (y < Y_LIM)  y         <= y + 1'b1;
                    if (y < Y_LAST) line_base <= line_base + LINE_STEP;
                end
                x           <= '0;
                phase       <= 1'b0;
                byte_cnt    <= '0;
                line_active <= 1'b1;
            end

            if (byte_ok) begin
                phase       <= ~phase_eff;
                line_active <= 1'b1;
                if (cnt_eff != CNT_SAT) byte_cnt <= cnt_eff + 1'b1;
                if (!phase_eff) begin
                    hold <= bus.in_data;
                end else begin
                    if (x < X_LIM) x <= x + 1'b1;
                    if ((x < X_LIM) && (y < Y_LIM)) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= line_base + ADDR_W'(x);
                        bus.wr_data <= pix444;
                    end else begin
                        bus.overflow <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
